// File: rtl/pipe_control_pkg.sv
// Shared definitions for the pipeline control slice: opcodes, ALUOp codes and
// the per-stage control bundles carried through EX, MEM and WB.
package pipe_control_pkg;

   localparam logic [6:0] OP_R      = 7'b0110011;
   localparam logic [6:0] OP_I      = 7'b0010011;
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_LUI    = 7'b0110111;

   typedef enum logic [2:0] {
      ALU_MEM    = 3'b000,
      ALU_BRANCH = 3'b001,
      ALU_RTYPE  = 3'b010,
      ALU_ITYPE  = 3'b011,
      ALU_JUMP   = 3'b100,
      ALU_LUI    = 3'b101
   } alu_op_e;

   typedef struct packed {
      logic    alusrc;
      logic    memtoreg;
      logic    regwrite;
      logic    memread;
      logic    memwrite;
      logic    branch;
      logic    jump;
      alu_op_e aluop;
      logic    illegal;
   } ctrl_t;

   typedef struct packed {
      logic memread;
      logic memwrite;
      logic memtoreg;
      logic regwrite;
   } mem_ctrl_t;

   typedef struct packed {
      logic memtoreg;
      logic regwrite;
   } wb_ctrl_t;

endpackage

// File: rtl/pipe_control_ctrl_decode.sv
// Combinational ID-stage decoder: opcode to control bundle plus which source
// registers the instruction actually reads (used by the load-use check).
module ctrl_decode
   import pipe_control_pkg::*;
#(
   parameter int OPCODE_W = 7,
   parameter int EN_JUMP  = 1
) (
   input  logic                i_valid,
   input  logic [OPCODE_W-1:0] i_opcode,
   output ctrl_t               o_ctrl,
   output logic                o_rs1_used,
   output logic                o_rs2_used
);

   localparam logic [OPCODE_W-1:0] OPC_R      = OPCODE_W'(OP_R);
   localparam logic [OPCODE_W-1:0] OPC_I      = OPCODE_W'(OP_I);
   localparam logic [OPCODE_W-1:0] OPC_LOAD   = OPCODE_W'(OP_LOAD);
   localparam logic [OPCODE_W-1:0] OPC_STORE  = OPCODE_W'(OP_STORE);
   localparam logic [OPCODE_W-1:0] OPC_BRANCH = OPCODE_W'(OP_BRANCH);
   localparam logic [OPCODE_W-1:0] OPC_JAL    = OPCODE_W'(OP_JAL);
   localparam logic [OPCODE_W-1:0] OPC_JALR   = OPCODE_W'(OP_JALR);
   localparam logic [OPCODE_W-1:0] OPC_LUI    = OPCODE_W'(OP_LUI);

   always_comb begin
      o_ctrl     = '0;
      o_rs1_used = 1'b0;
      o_rs2_used = 1'b0;
      if (i_valid) begin
         case (i_opcode)
            OPC_R: begin
               o_ctrl.regwrite = 1'b1;
               o_ctrl.aluop    = ALU_RTYPE;
               o_rs1_used      = 1'b1;
               o_rs2_used      = 1'b1;
            end
            OPC_I: begin
               o_ctrl.alusrc   = 1'b1;
               o_ctrl.regwrite = 1'b1;
               o_ctrl.aluop    = ALU_ITYPE;
               o_rs1_used      = 1'b1;
            end
            OPC_LOAD: begin
               o_ctrl.alusrc   = 1'b1;
               o_ctrl.memtoreg = 1'b1;
               o_ctrl.regwrite = 1'b1;
               o_ctrl.memread  = 1'b1;
               o_ctrl.aluop    = ALU_MEM;
               o_rs1_used      = 1'b1;
            end
            OPC_STORE: begin
               o_ctrl.alusrc   = 1'b1;
               o_ctrl.memwrite = 1'b1;
               o_ctrl.aluop    = ALU_MEM;
               o_rs1_used      = 1'b1;
               o_rs2_used      = 1'b1;
            end
            OPC_BRANCH: begin
               o_ctrl.branch = 1'b1;
               o_ctrl.aluop  = ALU_BRANCH;
               o_rs1_used    = 1'b1;
               o_rs2_used    = 1'b1;
            end
            // Jump-class opcodes are only legal in builds with jump support.
            OPC_JAL: begin
               if (EN_JUMP != 0) begin
                  o_ctrl.jump     = 1'b1;
                  o_ctrl.regwrite = 1'b1;
                  o_ctrl.aluop    = ALU_JUMP;
               end else begin
                  o_ctrl.illegal = 1'b1;
               end
            end
            OPC_JALR: begin
               if (EN_JUMP != 0) begin
                  o_ctrl.alusrc   = 1'b1;
                  o_ctrl.jump     = 1'b1;
                  o_ctrl.regwrite = 1'b1;
                  o_ctrl.aluop    = ALU_JUMP;
                  o_rs1_used      = 1'b1;
               end else begin
                  o_ctrl.illegal = 1'b1;
               end
            end
            OPC_LUI: begin
               if (EN_JUMP != 0) begin
                  o_ctrl.alusrc   = 1'b1;
                  o_ctrl.regwrite = 1'b1;
                  o_ctrl.aluop    = ALU_LUI;
               end else begin
                  o_ctrl.illegal = 1'b1;
               end
            end
            default: o_ctrl.illegal = 1'b1;
         endcase
      end
   end

endmodule

// File: rtl/pipe_control.sv
// Pipeline control: decodes the ID instruction, detects load-use hazards and
// carries control bits through the EX, MEM and WB stage registers.
module pipe_control
   import pipe_control_pkg::*;
#(
   parameter int OPCODE_W   = 7,
   parameter int ALU_OP_W   = 3,
   parameter int REG_ADDR_W = 5,
   parameter int EN_JUMP    = 1
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  id_valid,
   input  logic [OPCODE_W-1:0]   id_opcode,
   input  logic [REG_ADDR_W-1:0] id_rs1,
   input  logic [REG_ADDR_W-1:0] id_rs2,
   input  logic [REG_ADDR_W-1:0] id_rd,
   input  logic                  stall_ext,
   input  logic                  flush,
   output logic                  hazard_stall,
   output logic                  ex_alusrc,
   output logic                  ex_branch,
   output logic                  ex_jump,
   output logic                  ex_illegal,
   output logic [ALU_OP_W-1:0]   ex_aluop,
   output logic [REG_ADDR_W-1:0] ex_rd,
   output logic                  mem_memread,
   output logic                  mem_memwrite,
   output logic                  mem_memtoreg,
   output logic                  mem_regwrite,
   output logic [REG_ADDR_W-1:0] mem_rd,
   output logic                  wb_memtoreg,
   output logic                  wb_regwrite,
   output logic [REG_ADDR_W-1:0] wb_rd
);

   ctrl_t                 w_dec;
   logic                  w_rs1_used;
   logic                  w_rs2_used;
   logic                  w_hazard;

   ctrl_t                 r_ex;
   logic [REG_ADDR_W-1:0] r_ex_rd;
   mem_ctrl_t             r_mem;
   logic [REG_ADDR_W-1:0] r_mem_rd;
   wb_ctrl_t              r_wb;
   logic [REG_ADDR_W-1:0] r_wb_rd;

   ctrl_decode #(
      .OPCODE_W (OPCODE_W),
      .EN_JUMP  (EN_JUMP)
   ) u_decode (
      .i_valid    (id_valid),
      .i_opcode   (id_opcode),
      .o_ctrl     (w_dec),
      .o_rs1_used (w_rs1_used),
      .o_rs2_used (w_rs2_used)
   );

   // x0 is never a real destination, so a load to it cannot create a hazard.
   assign w_hazard = id_valid && r_ex.memread && (r_ex_rd != '0) &&
                     ((w_rs1_used && (id_rs1 == r_ex_rd)) ||
                      (w_rs2_used && (id_rs2 == r_ex_rd)));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_ex     <= '0;
         r_ex_rd  <= '0;
         r_mem    <= '0;
         r_mem_rd <= '0;
         r_wb     <= '0;
         r_wb_rd  <= '0;
      end else if (!stall_ext) begin
         r_mem.memread  <= r_ex.memread;
         r_mem.memwrite <= r_ex.memwrite;
         r_mem.memtoreg <= r_ex.memtoreg;
         r_mem.regwrite <= r_ex.regwrite;
         r_mem_rd       <= r_ex_rd;
         r_wb.memtoreg  <= r_mem.memtoreg;
         r_wb.regwrite  <= r_mem.regwrite;
         r_wb_rd        <= r_mem_rd;
         if (flush || w_hazard) begin
            r_ex    <= '0;
            r_ex_rd <= '0;
         end else begin
            r_ex    <= w_dec;
            r_ex_rd <= id_rd;
         end
      end
   end

   assign hazard_stall = w_hazard;
   assign ex_alusrc    = r_ex.alusrc;
   assign ex_branch    = r_ex.branch;
   assign ex_jump      = r_ex.jump;
   assign ex_illegal   = r_ex.illegal;
   assign ex_aluop     = ALU_OP_W'(r_ex.aluop);
   assign ex_rd        = r_ex_rd;
   assign mem_memread  = r_mem.memread;
   assign mem_memwrite = r_mem.memwrite;
   assign mem_memtoreg = r_mem.memtoreg;
   assign mem_regwrite = r_mem.regwrite;
   assign mem_rd       = r_mem_rd;
   assign wb_memtoreg  = r_wb.memtoreg;
   assign wb_regwrite  = r_wb.regwrite;
   assign wb_rd        = r_wb_rd;

endmodule
